// File: rtl/param_serial_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | param_serial_adder_if: start/busy/done handshake and operand bus   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface param_serial_adder_if #(
  parameter int SIZE = 4
);
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE-1:0] sum;
  logic            carry;
  logic            busy;
  logic            done;

  modport master (
    output start, a, b,
    input  sum, carry, busy, done
  );

  modport slave (
    input  start, a, b,
    output sum, carry, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/param_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | param_serial_adder: LSB-first bit-serial unsigned adder, SIZE bits |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module param_serial_adder #(
  parameter int SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  param_serial_adder_if.slave bus
);

  localparam int            CW     = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] a_sh_q, a_sh_d;
  logic [SIZE-1:0] b_sh_q, b_sh_d;
  logic [SIZE-1:0] psum_q, psum_d;
  logic [SIZE-1:0] sum_q, sum_d;
  logic            c_q, c_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            w_sbit;
  logic            w_cout;
  logic [SIZE:0]   w_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single full-adder cell; the sum bit enters the partial sum from the top.
  assign w_sbit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign w_cout  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
  assign w_shift = {w_sbit, psum_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    c_d     = c_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          psum_d  = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = w_cout;
        psum_d = w_shift[SIZE:1];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          sum_d   = w_shift[SIZE:1];
          carry_d = w_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.busy  = (state_q == ADD);
  assign bus.done  = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_param_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_param_serial_adder: directed checks of the serial adder         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_param_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  param_serial_adder_if #(.SIZE(4)) if4 ();
  param_serial_adder_if #(.SIZE(1)) if1 ();
  param_serial_adder_if #(.SIZE(8)) if8 ();
  param_serial_adder_if #(.SIZE(2)) if2 ();

  param_serial_adder #(.SIZE(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  param_serial_adder #(.SIZE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  param_serial_adder #(.SIZE(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
  param_serial_adder #(.SIZE(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full SIZE=4 addition, checking latency, busy length, result and strobe width.
  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] es, input logic ec);
    int n;
    int nb;
    if4.a     = a;
    if4.b     = b;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    n  = 0;
    nb = 0;
    while (!if4.done && n < 20) begin
      if (if4.busy) nb++;
      tick();
      n++;
    end
    chk({tag, "_lat"},   n, 4);
    chk({tag, "_busyn"}, nb, 4);
    chk({tag, "_sum"},   {28'd0, if4.sum}, {28'd0, es});
    chk({tag, "_carry"}, {31'd0, if4.carry}, {31'd0, ec});
    chk({tag, "_busy0"}, {31'd0, if4.busy}, 32'd0);
    tick();
    chk({tag, "_done1c"}, {31'd0, if4.done}, 32'd0);
    chk({tag, "_hold"},  {28'd0, if4.sum}, {28'd0, es});
  endtask

  initial begin
    int n;
    int nd;
    logic [2:0] e2;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sum",   {28'd0, if4.sum}, 32'd0);
    chk("rst_carry", {31'd0, if4.carry}, 32'd0);
    chk("rst_busy",  {31'd0, if4.busy}, 32'd0);
    chk("rst_done",  {31'd0, if4.done}, 32'd0);

    op4("t3p5", 4'b0011, 4'b0101, 4'b1000, 1'b0);
    op4("tFp1", 4'b1111, 4'b0001, 4'b0000, 1'b1);
    op4("tFpF", 4'b1111, 4'b1111, 4'b1110, 1'b1);
    op4("t0p0", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // start pulse and operand change during ADD must be ignored
    if4.a = 4'b0110; if4.b = 4'b0011; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    if4.a = 4'b1111; if4.b = 4'b1111; if4.start = 1'b1;
    tick();
    if4.start = 1'b0; if4.a = 4'b0000; if4.b = 4'b0000;
    n = 0;
    while (!if4.done && n < 20) begin tick(); n++; end
    chk("ign_lat",   n, 2);
    chk("ign_sum",   {28'd0, if4.sum}, 32'h9);
    chk("ign_carry", {31'd0, if4.carry}, 32'd0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (if4.done) nd++; end
    chk("ign_onedone", nd, 0);

    // reset in the second ADD cycle aborts
    if4.a = 4'b1010; if4.b = 4'b0111; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  {31'd0, if4.busy}, 32'd0);
    chk("abort_done",  {31'd0, if4.done}, 32'd0);
    chk("abort_sum",   {28'd0, if4.sum}, 32'd0);
    chk("abort_carry", {31'd0, if4.carry}, 32'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (if4.done) nd++; end
    chk("abort_nodone", nd, 0);
    op4("tAp7", 4'b1010, 4'b0111, 4'b0001, 1'b1);

    // SIZE=1
    if1.a = 1'b1; if1.b = 1'b1; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    chk("s1_busy",  {31'd0, if1.busy}, 32'd1);
    chk("s1_done0", {31'd0, if1.done}, 32'd0);
    tick();
    chk("s1_done",  {31'd0, if1.done}, 32'd1);
    chk("s1_sum",   {31'd0, if1.sum}, 32'd0);
    chk("s1_carry", {31'd0, if1.carry}, 32'd1);
    chk("s1_busy0", {31'd0, if1.busy}, 32'd0);
    tick();
    chk("s1_done1c", {31'd0, if1.done}, 32'd0);

    // SIZE=8
    if8.a = 8'hFF; if8.b = 8'h01; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    n = 1;
    while (!if8.done && n < 30) begin tick(); n++; end
    chk("s8_edges", n, 9);
    chk("s8_sum",   {24'd0, if8.sum}, 32'h00);
    chk("s8_carry", {31'd0, if8.carry}, 32'd1);

    // SIZE=2 exhaustive with start held high
    if2.a = 2'd0; if2.b = 2'd0; if2.start = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      while (!if2.done && n < 20) begin tick(); n++; end
      chk("s2_doneseen", {31'd0, if2.done}, 32'd1);
      e2 = 3'(i >> 2) + 3'(i & 3);
      chk($sformatf("s2_sum_%0d", i),   {30'd0, if2.sum}, {30'd0, e2[1:0]});
      chk($sformatf("s2_carry_%0d", i), {31'd0, if2.carry}, {31'd0, e2[2]});
      if (i > 0) chk($sformatf("s2_space_%0d", i), n, 4);
      if (i < 15) begin
        if2.a = 2'((i + 1) >> 2);
        if2.b = 2'((i + 1) & 3);
      end else begin
        if2.start = 1'b0;
      end
      tick();
      n = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_serial_adder.md
# param_serial_adder

Bit-serial, parameterized unsigned adder: the addition counterpart to the parallel parameterized subtractor in the parameters library. It accepts two SIZE-bit operands on a start pulse, adds them one bit per clock LSB-first through a single full-adder cell and carry flop, then presents a registered sum and carry-out with a one-cycle done strobe. It is used where area matters more than latency, and as the library's reference for a start/busy/done handshake on a parameterized datapath.

## Interface
- SIZE, default 4: operand and sum width in bits; legal range SIZE >= 1.

- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  SIZE  augend; captured on the accepted start edge.
- b  input  SIZE  addend; captured on the accepted start edge.
- sum  output  SIZE  registered result (a + b) mod 2^SIZE.
- carry  output  1  registered carry-out, bit SIZE of a + b.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle strobe marking a new valid sum/carry.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge:
  - load a and b into internal shift registers;
  - clear the internal carry flop and the bit counter;
  - go to ADD.
- ADD: busy=1. Each edge:
  - sum bit = a_sh[0] ^ b_sh[0] ^ c;
  - c <= majority(a_sh[0], b_sh[0], c);
  - shift a_sh and b_sh right by one;
  - shift the sum bit into the MSB of the partial-sum shift register;
  - increment the counter.
- Leave ADD on the edge that processes bit SIZE-1:
  - copy the completed partial sum into sum and the final carry into carry;
  - go to DONE.
- DONE: busy=0, done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- start is ignored in ADD. Operand changes after capture have no effect.
- sum and carry change only on the ADD→DONE edge. They are stable during ADD and hold their values until the next completion.
- Counter width is $clog2(SIZE)+1 bits, so SIZE=1 works. With SIZE=1, ADD lasts one cycle.
- Arithmetic is unsigned. {carry, sum} equals a + b exactly, as a (SIZE+1)-bit value.

## Timing
- Reset values (rst=1 at an edge): state=IDLE, sum=0, carry=0, busy=0, done=0; internal shift registers, carry flop and counter all 0.
- rst has priority over start and over any in-progress state.
- Reset during ADD or DONE aborts the operation. No done pulse is produced, and sum/carry read 0 from the following cycle.
- Start accepted at edge k:
  - busy=1 after edges k through k+SIZE-1 (SIZE cycles);
  - sum/carry update and done=1 after edge k+SIZE;
  - back in IDLE after edge k+SIZE+1.
- Latency from accepted start to done: SIZE+1 edges.
- Throughput: one addition per SIZE+2 cycles. The earliest next start is accepted at edge k+SIZE+2.
- start held high continuously starts a new addition every SIZE+2 cycles, with operands captured at each acceptance edge.
- done and busy are never high together.

## Test plan
- SIZE=4, a=0011, b=0101, one-cycle start -> busy high 4 cycles; done after edge k+4 with sum=1000, carry=0.
- SIZE=4, a=1111, b=0001 -> sum=0000, carry=1. Then a=1111, b=1111 -> sum=1110, carry=1. Then a=0000, b=0000 -> sum=0000, carry=0.
- SIZE=4, a=0110, b=0011 started; change a/b and pulse start during ADD -> pulse ignored; result is sum=1001, carry=0; exactly one done.
- SIZE=4, a=1010, b=0111 started; assert rst for one cycle at the 2nd ADD cycle -> no done; sum=0000, carry=0, busy=0. A fresh start after reset with a=1010, b=0111 gives sum=0001, carry=1.
- SIZE=1: 1+1 -> done after edge k+1, sum=0, carry=1. SIZE=8: 0xFF+0x01 -> sum=0x00, carry=1 after 9 edges.
- Exhaustive SIZE=2 (all 16 operand pairs, back-to-back starts held high) -> every result matches a+b; done spacing is exactly 4 cycles.
